clock_hms: RTL and testbench

- Parametrised HH:MM:SS digital clock; successor to the single-digit seconds counter.
- Contains:
  - an internal prescaler generating a one-cycle seconds tick
  - a cascaded seconds/minutes/hours BCD counter chain with carries
  - a run/pause control
  - a set mode with switch-driven minute/hour increment
  - six 7-segment decoders
- Sits at board top level, driving HEX0..HEX5 directly.

---
 rtl/clock_hms.sv | 133 +++++++++++++
 tb/tb_clock_hms.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_hms.sv
// HH:MM:SS clock: prescaled seconds tick, BCD seconds/minutes/hours chain,
// run/pause/set control and six active-low 7-segment digit outputs.
module clock_hms #(
  parameter int unsigned DIV   = 50000000,
  parameter int unsigned HOURS = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       TICK
);

  localparam int unsigned   PW         = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [7:0]    BCD_59     = 8'h59;
  localparam logic [7:0]    HR_LAST    = {4'((HOURS - 1) / 10), 4'((HOURS - 1) % 10)};

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_PAUSE,
    MODE_SET
  } mode_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hr_q, hr_d;
  logic [3:0]    sw_s1_q, sw_s2_q, sw_d_q;
  logic [3:0]    sw_rise;
  mode_e         mode;

  // Packed BCD {tens, ones} increment, wrapping to 00 after the given last value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign sw_rise = sw_s2_q & ~sw_d_q;

  always_comb begin
    if (sw_s2_q[1])
      mode = MODE_SET;
    else if (sw_s2_q[0])
      mode = MODE_PAUSE;
    else
      mode = MODE_RUN;
  end

  assign TICK = (mode == MODE_RUN) && (presc_q == PRESC_LAST);

  // Whole sec->min->hour carry chain resolves combinationally within one tick.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    case (mode)
      MODE_SET: begin
        presc_d = '0;
        sec_d   = '0;
        if (sw_rise[2]) min_d = bcd_inc(min_q, BCD_59);
        if (sw_rise[3]) hr_d  = bcd_inc(hr_q, HR_LAST);
      end
      MODE_RUN: begin
        if (TICK) begin
          presc_d = '0;
          sec_d   = bcd_inc(sec_q, BCD_59);
          if (sec_q == BCD_59) begin
            min_d = bcd_inc(min_q, BCD_59);
            if (min_q == BCD_59) hr_d = bcd_inc(hr_q, HR_LAST);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      sw_d_q  <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      sw_d_q  <= sw_s2_q;
    end
  end

  assign HEX0 = seg7(sec_q[3:0]);
  assign HEX1 = seg7(sec_q[7:4]);
  assign HEX2 = seg7(min_q[3:0]);
  assign HEX3 = seg7(min_q[7:4]);
  assign HEX4 = seg7(hr_q[3:0]);
  assign HEX5 = seg7(hr_q[7:4]);

endmodule

// File: tb/tb_clock_hms.sv
// Bench for clock_hms: a 24-hour and a 12-hour instance, checked each cycle
// against a total-seconds model plus directed literal expectations.
module tb_clock_hms;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst24, rst12;
  logic [3:0]      sw24, sw12;
  logic [5:0][6:0] hx24, hx12;
  logic            tick24, tick12;

  clock_hms #(.DIV(DIV), .HOURS(24)) dut24 (
    .CLK(clk), .RST(rst24), .SW(sw24),
    .HEX0(hx24[0]), .HEX1(hx24[1]), .HEX2(hx24[2]),
    .HEX3(hx24[3]), .HEX4(hx24[4]), .HEX5(hx24[5]),
    .TICK(tick24)
  );

  clock_hms #(.DIV(DIV), .HOURS(12)) dut12 (
    .CLK(clk), .RST(rst12), .SW(sw12),
    .HEX0(hx12[0]), .HEX1(hx12[1]), .HEX2(hx12[2]),
    .HEX3(hx12[3]), .HEX4(hx12[4]), .HEX5(hx12[5]),
    .TICK(tick12)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] SEGTAB [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [41:0] ZEROS = {6{7'b1000000}};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    return SEGTAB[d];
  endfunction

  function automatic logic [41:0] disp(input int h, input int m, input int s);
    return {seg(h / 10), seg(h % 10), seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)};
  endfunction

  function automatic int hrs(input int i);
    return (i == 0) ? 24 : 12;
  endfunction

  // Model: time as total seconds, switch history as the values sampled at past edges.
  int         secs  [2];
  int         presc [2];
  logic [3:0] p1 [2];
  logic [3:0] p2 [2];
  logic [3:0] p3 [2];
  bit         valid [2] = '{1'b0, 1'b0};
  logic       m_r;
  logic [3:0] m_sw, m_rise;
  int         m_hh, m_mm;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_r  = (i == 0) ? rst24 : rst12;
      m_sw = (i == 0) ? sw24 : sw12;
      if (!m_r) begin
        secs[i] = 0; presc[i] = 0;
        p1[i] = '0; p2[i] = '0; p3[i] = '0;
        valid[i] = 1'b1;
      end else begin
        m_rise = p2[i] & ~p3[i];
        if (p2[i][1]) begin
          presc[i] = 0;
          m_hh = secs[i] / 3600;
          m_mm = (secs[i] / 60) % 60;
          if (m_rise[2]) m_mm = (m_mm + 1) % 60;
          if (m_rise[3]) m_hh = (m_hh + 1) % hrs(i);
          secs[i] = m_hh * 3600 + m_mm * 60;
        end else if (!p2[i][0]) begin
          if (presc[i] == DIV - 1) begin
            presc[i] = 0;
            secs[i]  = (secs[i] + 1) % (hrs(i) * 3600);
          end else begin
            presc[i]++;
          end
        end
        p3[i] = p2[i]; p2[i] = p1[i]; p1[i] = m_sw;
      end
    end
  end

  function automatic logic [42:0] exp_out(input int i);
    logic t;
    t = (p2[i][1:0] == 2'b00) && (presc[i] == DIV - 1);
    return {disp(secs[i] / 3600, (secs[i] / 60) % 60, secs[i] % 60), t};
  endfunction

  always @(negedge clk) begin
    if (valid[0]) chk("cyc24", {hx24, tick24}, exp_out(0));
    if (valid[1]) chk("cyc12", {hx12, tick12}, exp_out(1));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_bit(input int which, input int b, input logic v);
    if (which == 0) sw24[b] = v;
    else            sw12[b] = v;
  endtask

  task automatic pulse(input int which, input int b, input int n, input int hold);
    repeat (n) begin
      set_bit(which, b, 1'b1); cyc(hold);
      set_bit(which, b, 1'b0); cyc(hold);
    end
  endtask

  task automatic do_reset(input int which);
    if (which == 0) begin rst24 = 1'b0; sw24 = '0; end
    else            begin rst12 = 1'b0; sw12 = '0; end
    cyc(2);
    if (which == 0) rst24 = 1'b1;
    else            rst12 = 1'b1;
  endtask

  task automatic check_time(input string nm, input int which, input int h, input int m, input int s);
    chk(nm, (which == 0) ? hx24 : hx12, disp(h, m, s));
  endtask

  task automatic set_time(input int which, input int h, input int m);
    do_reset(which);
    if (which == 0) sw24 = 4'b0010;
    else            sw12 = 4'b0010;
    cyc(3);
    pulse(which, 3, h, 5);
    pulse(which, 2, m, 5);
  endtask

  task automatic run(input int which);
    if (which == 0) sw24 = '0;
    else            sw12 = '0;
  endtask

  task automatic wait_ticks(input string nm, input int which, input int n);
    int cnt = 0;
    int k   = 0;
    int lim = n * DIV * 2 + 20;
    while (cnt < n && k < lim) begin
      cyc(1);
      k++;
      if (((which == 0) ? tick24 : tick12) === 1'b1) cnt++;
    end
    if (cnt < n) begin
      total++; bad++;
      $display("FAIL %s: timeout, got %0d ticks want %0d", nm, cnt, n);
    end
    cyc(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    rst24 = 1'b0; rst12 = 1'b0; sw24 = '0; sw12 = '0;
    cyc(2);
    chk("rst_hex", hx24, ZEROS);
    chk("rst_tick", tick24, 1'b0);

    // 1: free run from reset
    rst24 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      chk("t1_tick", tick24, (i % 4 == 3) ? 1'b1 : 1'b0);
    end
    chk("t1_hex0", hx24[0], 7'b0011001);
    chk("t1_hex51", hx24[5:1], {5{7'b1000000}});

    // 2: carries and day wrap
    set_time(0, 23, 59);
    check_time("t2_set", 0, 23, 59, 0);
    run(0);
    wait_ticks("t2_w59", 0, 59);
    check_time("t2_235959", 0, 23, 59, 59);
    wait_ticks("t2_w1", 0, 1);
    chk("t2_wrap", hx24, ZEROS);
    set_time(0, 0, 9);
    run(0);
    wait_ticks("t2b_w59", 0, 59);
    check_time("t2_000959", 0, 0, 9, 59);
    wait_ticks("t2b_w1", 0, 1);
    check_time("t2_001000", 0, 0, 10, 0);
    set_time(0, 9, 59);
    run(0);
    wait_ticks("t2c_w59", 0, 59);
    check_time("t2_095959", 0, 9, 59, 59);
    wait_ticks("t2c_w1", 0, 1);
    check_time("t2_100000", 0, 10, 0, 0);

    // 3: minute increments in set mode
    set_time(0, 3, 61);
    check_time("t3_61", 0, 3, 1, 0);
    sw24[2] = 1'b1; cyc(100); sw24[2] = 1'b0; cyc(5);
    check_time("t3_hold", 0, 3, 2, 0);
    sw24[2] = 1'b1;
    cyc(1); check_time("t3_lat_k", 0, 3, 2, 0);
    cyc(1); check_time("t3_lat_k1", 0, 3, 2, 0);
    cyc(1); check_time("t3_lat_k2", 0, 3, 3, 0);
    sw24[2] = 1'b0; cyc(5);

    // 4: 12-hour instance
    set_time(1, 13, 0);
    check_time("t4_13", 1, 1, 0, 0);
    pulse(1, 3, 10, 5);
    pulse(1, 2, 59, 5);
    check_time("t4_set", 1, 11, 59, 0);
    run(1);
    wait_ticks("t4_w59", 1, 59);
    check_time("t4_115959", 1, 11, 59, 59);
    wait_ticks("t4_w1", 1, 1);
    chk("t4_wrap", hx12, ZEROS);

    // 5: pause with the prescaler frozen at 2
    rst24 = 1'b0; sw24 = '0; cyc(2);
    rst24 = 1'b1; sw24 = 4'b0001;
    nt = 0;
    repeat (50) begin
      cyc(1);
      if (tick24 !== 1'b0) nt++;
    end
    chk("t5_noticks", nt, 0);
    check_time("t5_frozen", 0, 0, 0, 0);
    sw24 = '0;
    cyc(1); chk("t5_tick_a", tick24, 1'b0);
    cyc(1); chk("t5_tick_b", tick24, 1'b0);
    cyc(1); chk("t5_tick_c", tick24, 1'b1);
    cyc(1); check_time("t5_resume", 0, 0, 0, 1);

    // 6: reset mid-run, mid-set, and a switch held across release
    set_time(0, 12, 34);
    run(0);
    wait_ticks("t6_w56", 0, 56);
    check_time("t6_123456", 0, 12, 34, 56);
    rst24 = 1'b0;
    cyc(1);
    chk("t6_rst_run", {hx24, tick24}, {ZEROS, 1'b0});
    rst24 = 1'b1; sw24 = 4'b0010; cyc(3);
    pulse(0, 2, 3, 3);
    check_time("t6_set3", 0, 0, 3, 0);
    sw24[2] = 1'b1; cyc(1);
    rst24 = 1'b0;
    cyc(1);
    chk("t6_rst_set", {hx24, tick24}, {ZEROS, 1'b0});
    sw24 = 4'b0100; cyc(2);
    rst24 = 1'b1; cyc(6);
    sw24 = 4'b0110; cyc(10);
    check_time("t6_no_stale", 0, 0, 0, 0);
    sw24[2] = 1'b0; cyc(5);
    sw24[2] = 1'b1; cyc(5);
    check_time("t6_fresh", 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
